// File: rtl/mutative_types_pkg.sv
// Shared types for the mutative cache: address layout and organisation encoding.
package mutative_types;

  localparam int TAG_BITS    = 23;
  localparam int SET_BITS    = 4;
  localparam int OFFSET_BITS = 5;
  localparam int WAYS        = 8;
  localparam int NUM_SETS    = 1 << SET_BITS;
  // DM, 2, 4 and 8 ways need one code each.
  localparam int SETUP_BITS  = $clog2($clog2(WAYS) + 1);

  typedef enum logic [SETUP_BITS-1:0] {
    SETUP_DM   = 2'd0,
    SETUP_2WAY = 2'd1,
    SETUP_4WAY = 2'd2,
    SETUP_8WAY = 2'd3
  } setup_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [SET_BITS-1:0]    set_index;
    logic [OFFSET_BITS-1:0] offset;
  } cache_address_t;

endpackage

// File: rtl/set_tag_table.sv
// Last-seen tag per set; valid bits clear on reset, tags are plain storage.
module set_tag_table
  import mutative_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] index,
  input  logic                wr_en,
  input  logic [TAG_BITS-1:0] wr_tag,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (wr_en) valid_q[index] <= 1'b1;
  end

  // Tags need no reset: they are only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) tag_q[index] <= wr_tag;
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];

endmodule

// File: rtl/associativity_selector.sv
// Watches completed accesses over a fixed window and requests a step up/down
// of cache associativity through a valid/ready handshake.
module associativity_selector
  import mutative_types::*;
#(
  parameter int WINDOW    = 256,
  parameter int HI_THRESH = 64,
  parameter int LO_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cache_address,
  input  logic                  cpu_request,
  input  logic                  cache_ready,
  input  logic [SETUP_BITS-1:0] setup,
  input  logic                  plru_bit0,
  input  logic                  tie,
  input  logic                  setup_ready,
  output logic                  setup_valid,
  output logic [SETUP_BITS-1:0] setup_update
);

  localparam int CNT_W = $clog2(WINDOW) + 1;
  localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(WINDOW / 2);
  localparam logic [CNT_W-1:0] HI_C     = CNT_W'(HI_THRESH);
  localparam logic [CNT_W-1:0] LO_C     = CNT_W'(LO_THRESH);

  cache_address_t      addr;
  logic                count_en;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic                conflict;
  logic [CNT_W-1:0]    acc_cnt, conf_cnt, tie_cnt;
  logic [CNT_W-1:0]    acc_next, conf_next, tie_next;
  logic                window_end, step_up, step_down;
  logic                unused_inputs;

  assign addr          = cache_address;
  assign unused_inputs = ^{plru_bit0, addr.offset};

  assign count_en = cpu_request && cache_ready && !setup_valid;

  set_tag_table u_table (
    .clk      (clk),
    .rst      (rst),
    .index    (addr.set_index),
    .wr_en    (count_en),
    .wr_tag   (addr.tag),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag)
  );

  assign conflict = rd_valid && (rd_tag != addr.tag);

  // Decision sees the counts including the access that closes the window.
  always_comb begin
    acc_next   = acc_cnt + 1'b1;
    conf_next  = conf_cnt + CNT_W'(conflict);
    tie_next   = tie_cnt + CNT_W'(tie);
    window_end = count_en && (acc_next == WINDOW_C);
    step_up    = (conf_next >= HI_C) && (setup != SETUP_8WAY);
    step_down  = !step_up && (conf_next < LO_C) && (tie_next >= HALF_C)
                 && (setup != SETUP_DM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt      <= '0;
      conf_cnt     <= '0;
      tie_cnt      <= '0;
      setup_valid  <= 1'b0;
      setup_update <= '0;
    end else if (setup_valid) begin
      if (setup_ready) setup_valid <= 1'b0;
    end else if (count_en) begin
      if (window_end) begin
        acc_cnt  <= '0;
        conf_cnt <= '0;
        tie_cnt  <= '0;
        if (step_up) begin
          setup_valid  <= 1'b1;
          setup_update <= setup + 2'd1;
        end else if (step_down) begin
          setup_valid  <= 1'b1;
          setup_update <= setup - 2'd1;
        end
      end else begin
        acc_cnt  <= acc_next;
        conf_cnt <= conf_next;
        tie_cnt  <= tie_next;
      end
    end
  end

endmodule

// File: tb/tb_associativity_selector.sv
// Directed bench: stimulus pushes expected requests, a negedge monitor checks them.
module tb_associativity_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cache_address;
  logic        cpu_request, cache_ready, plru_bit0, tie, setup_ready;
  logic [1:0]  setup;
  logic        setup_valid;
  logic [1:0]  setup_update;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [1:0] held_update = 2'd0;

  always #5 clk = ~clk;

  associativity_selector dut (
    .clk          (clk),
    .rst          (rst),
    .cache_address(cache_address),
    .cpu_request  (cpu_request),
    .cache_ready  (cache_ready),
    .setup        (setup),
    .plru_bit0    (plru_bit0),
    .tie          (tie),
    .setup_ready  (setup_ready),
    .setup_valid  (setup_valid),
    .setup_update (setup_update)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: new request -> pop and compare; held request -> must not change.
  always @(negedge clk) begin
    if (setup_valid && !prev_valid) begin
      if (exp_q.size() == 0) check("unexpected_request", {31'd0, setup_valid}, 32'd0);
      else check("request_value", {30'd0, setup_update}, {30'd0, exp_q.pop_front()});
      held_update = setup_update;
    end else if (setup_valid && prev_valid) begin
      check("update_stable", {30'd0, setup_update}, {30'd0, held_update});
    end
    prev_valid = setup_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    cpu_request = 1'b0;
    cache_ready = 1'b0;
    tie = 1'b0;
  endtask

  // 256 counted accesses; tag toggles ta/tb for i<=toggle_n, else ta; tie for i<tie_n.
  task automatic run_window(input int toggle_n, input logic [22:0] ta, input logic [22:0] tb,
                            input logic [3:0] s, input int tie_n,
                            input bit expect_req, input logic [1:0] exp_upd);
    if (expect_req) exp_q.push_back(exp_upd);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i > 0) check("no_early_valid", {31'd0, setup_valid}, 32'd0);
      cpu_request   = 1'b1;
      cache_ready   = 1'b1;
      plru_bit0     = i[1];
      tie           = (i < tie_n);
      cache_address = {((i <= toggle_n) && i[0]) ? tb : ta, s, i[4:0]};
    end
    @(negedge clk);
    idle();
    check("window_end_valid", {31'd0, setup_valid}, {31'd0, expect_req});
  endtask

  task automatic handshake();
    @(negedge clk);
    setup_ready = 1'b1;
    @(negedge clk);
    setup_ready = 1'b0;
    check("valid_after_ready", {31'd0, setup_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cache_address = '0;
    plru_bit0 = 1'b0;
    setup_ready = 1'b0;
    setup = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_valid", {31'd0, setup_valid}, 32'd0);
    check("reset_update", {30'd0, setup_update}, 32'd0);
    setup_ready = 1'b1;
    @(negedge clk);
    setup_ready = 1'b0;
    rst = 1'b0;
    check("ready_while_idle", {31'd0, setup_valid}, 32'd0);

    // Conflict up-step from DM, then hold with accesses and a changing setup.
    run_window(255, 23'h1, 23'h2, 4'd0, 0, 1'b1, 2'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, setup_valid}, 32'd1);
      check("hold_update", {30'd0, setup_update}, 32'd1);
      cpu_request = 1'b1;
      cache_ready = 1'b1;
      setup = 2'(i);
      cache_address = {23'(i + 7), 4'd0, 5'd0};
    end
    setup = 2'd0;
    handshake();
    idle();

    // Pending-time accesses ignored: full window needed again.
    run_window(255, 23'h1, 23'h2, 4'd0, 0, 1'b1, 2'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_valid", {31'd0, setup_valid}, 32'd0);
    check("async_reset_update", {30'd0, setup_update}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation at 8-way, then counters must have cleared.
    setup = 2'd3;
    run_window(255, 23'h1, 23'h2, 4'd0, 0, 1'b0, 2'd0);
    setup = 2'd0;
    run_window(255, 23'h1, 23'h2, 4'd0, 0, 1'b1, 2'd1);
    handshake();

    // Down-steps need few conflicts and at least half ties.
    setup = 2'd2;
    run_window(0, 23'h5, 23'h5, 4'd3, 256, 1'b1, 2'd1);
    handshake();
    run_window(0, 23'h5, 23'h5, 4'd3, 0, 1'b0, 2'd0);

    // Gating: responses without cache_ready never count.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cpu_request = 1'b1;
      cache_ready = 1'b0;
      tie = 1'b1;
    end
    @(negedge clk);
    idle();
    check("gated_no_request", {31'd0, setup_valid}, 32'd0);
    run_window(0, 23'h5, 23'h5, 4'd3, 128, 1'b1, 2'd1);
    handshake();
    run_window(0, 23'h5, 23'h5, 4'd3, 127, 1'b0, 2'd0);

    // Threshold boundaries: 64 conflicts steps up, 62 does not; 14 steps down, 16 does not.
    setup = 2'd1;
    run_window(64, 23'h10, 23'h11, 4'd5, 0, 1'b1, 2'd2);
    handshake();
    run_window(62, 23'h20, 23'h21, 4'd6, 0, 1'b0, 2'd0);
    setup = 2'd2;
    run_window(16, 23'h30, 23'h31, 4'd8, 256, 1'b0, 2'd0);
    run_window(14, 23'h40, 23'h41, 4'd7, 256, 1'b1, 2'd1);
    handshake();

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
